// File: rtl/mem44_seq_pkg.sv
// Shared definitions for the 4x4 matrix loader / skewed column streamer.
// Holds the FSM encoding, matrix geometry and the phase lengths.
package mem44_seq_pkg;

  localparam int N             = 4;
  localparam int DW            = 8;
  localparam int LOAD_COUNT    = 16;
  localparam int STREAM_CYCLES = 4;
  localparam int DRAIN_CYCLES  = N - 1;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Terminal value of the shared phase counter for a phase lasting 'cycles'.
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem44_seq_if.sv
// Control, load-handshake, memory and array-output bundle of mem44_seq.
// The slave modport is the sequencer's view, the master modport its environment.
interface mem44_seq_if #(
  parameter int N  = 4,
  parameter int DW = 8
);

  logic            load;
  logic            start;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            mem_we;
  logic [3:0]      mem_addr;
  logic [DW-1:0]   mem_data;
  logic [N*DW-1:0] mem_col;
  logic            arr_valid;
  logic [N*DW-1:0] arr_data;
  logic            busy;
  logic            loaded;
  logic            done;

  modport slave (
    input  load, start, in_valid, in_data, mem_col,
    output in_ready, mem_we, mem_addr, mem_data,
    output arr_valid, arr_data, busy, loaded, done
  );

  modport master (
    output load, start, in_valid, in_data, mem_col,
    input  in_ready, mem_we, mem_addr, mem_data,
    input  arr_valid, arr_data, busy, loaded, done
  );

endinterface

// File: rtl/sa_skew.sv
// Per-lane delay line feeding a systolic array: lane k passes through k
// delay registers and one output register, so it trails lane 0 by k cycles.
module sa_skew #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic [N*DW-1:0] col_in,
  output logic [N*DW-1:0] arr_data
);

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DW-1:0] pipe [0:k];

    // Zeros are shifted in whenever no column is being captured.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= k; j++) pipe[j] <= '0;
      end else begin
        pipe[0] <= capture ? col_in[k*DW +: DW] : '0;
        for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
      end
    end

    assign arr_data[k*DW +: DW] = pipe[k];
  end

endmodule

// File: rtl/mem44_seq.sv
// Loads a 4x4 matrix row-major into an external memory, then streams its
// columns through a lane skew so each row enters a systolic array in turn.
module mem44_seq #(
  parameter int N  = mem44_seq_pkg::N,
  parameter int DW = mem44_seq_pkg::DW
) (
  input  logic       clk,
  input  logic       reset,
  mem44_seq_if.slave bus
);
  import mem44_seq_pkg::*;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             loaded_q, loaded_nx;
  logic             arr_valid_q, done_q;
  logic             capture;
  logic             in_ready_c, mem_we_c;
  logic [3:0]       mem_addr_c;
  logic [DW-1:0]    mem_data_c;
  logic             active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      loaded_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      loaded_q <= loaded_nx;
    end
  end

  // One counter serves as element index in LOAD, column index in STREAM
  // and drain timer in DRAIN.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    loaded_nx  = loaded_q;
    capture    = 1'b0;
    in_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = 4'd0;
    mem_data_c = '0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          state_nx  = LOAD;
          cnt_nx    = '0;
          loaded_nx = 1'b0;
        end else if (bus.start && loaded_q) begin
          state_nx = STREAM;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        mem_addr_c = cnt;
        if (bus.in_valid) begin
          mem_we_c   = 1'b1;
          mem_data_c = bus.in_data;
          if (cnt == last_count(LOAD_COUNT)) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            loaded_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      STREAM: begin
        capture    = 1'b1;
        mem_addr_c = {2'b00, cnt[1:0]};
        if (cnt == last_count(STREAM_CYCLES)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == last_count(DRAIN_CYCLES)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign active = (state == STREAM) || (state == DRAIN);

  // Output registers trail the state by one cycle; done marks the first
  // cycle after the final valid array word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      arr_valid_q <= active;
      done_q      <= arr_valid_q && !active;
    end
  end

  sa_skew #(
    .N  (N),
    .DW (DW)
  ) u_skew (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .col_in   (bus.mem_col),
    .arr_data (bus.arr_data)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_data  = mem_data_c;
  assign bus.arr_valid = arr_valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.loaded    = loaded_q;
  assign bus.done      = done_q;

endmodule
